// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: decodes CPU word accesses to a synchronous RAM,
// an LED register, a synchronised switch port and a free-running counter.
//
// state  | meaning
// IDLE   | waiting for CPU_MIO, latches the request when it arrives
// ACCESS | RAM strobe issued, or peripheral read/write performed
// WAIT   | RAM read data returning, captured into Data_in
// DONE   | MIO_ready pulse, then back to IDLE
module mio_responder #(
  parameter int          RAM_AW   = 10,
  parameter logic [15:0] LED_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    T_RAM  = 3'd0,
    T_LED  = 3'd1,
    T_SW   = 3'd2,
    T_CNT  = 3'd3,
    T_NONE = 3'd4
  } target_t;

  localparam logic [31:0] LED_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

  state_t            state_q;
  target_t           tgt_q;
  target_t           req_tgt;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       data_q;
  logic              we_q;
  logic [31:0]       cnt_q;
  logic [15:0]       sw_meta;
  logic [15:0]       sw_sync;
  logic              cnt_load;
  logic              unused_addr_lsb;

  // Byte lane bits carry no meaning: every access is a full word.
  function automatic target_t decode(input logic [31:0] a);
    if (a[31:RAM_AW+2] == '0)          return T_RAM;
    else if (a[31:2] == LED_ADDR[31:2]) return T_LED;
    else if (a[31:2] == SW_ADDR[31:2])  return T_SW;
    else if (a[31:2] == CNT_ADDR[31:2]) return T_CNT;
    else                                return T_NONE;
  endfunction

  assign req_tgt         = decode(Addr_out);
  assign unused_addr_lsb = ^Addr_out[1:0];

  assign state    = state_q;
  assign ram_addr = addr_q;
  assign ram_din  = data_q;
  assign cnt_load = (state_q == S_ACCESS) && we_q && (tgt_q == T_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (cnt_load) cnt_q <= data_q;
    else               cnt_q <= cnt_q + 32'd1;
  end

  // RAM strobes are registered on the accepting edge so they are high
  // exactly for the ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tgt_q     <= T_NONE;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      Data_in   <= '0;
      MIO_ready <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      led       <= LED_INIT;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      MIO_ready <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CPU_MIO) begin
            addr_q  <= Addr_out[RAM_AW+1:2];
            data_q  <= Data_out;
            we_q    <= mem_w;
            tgt_q   <= req_tgt;
            state_q <= S_ACCESS;
            if (req_tgt == T_RAM) begin
              ram_en <= 1'b1;
              ram_we <= mem_w;
            end
          end
        end
        S_ACCESS: begin
          if (tgt_q == T_RAM && !we_q) begin
            state_q <= S_WAIT;
          end else begin
            state_q   <= S_DONE;
            MIO_ready <= 1'b1;
          end
          if (we_q) begin
            if (tgt_q == T_LED) led <= data_q[15:0];
          end else begin
            case (tgt_q)
              T_LED:   Data_in <= {16'h0000, led};
              T_SW:    Data_in <= {16'h0000, sw_sync};
              T_CNT:   Data_in <= cnt_q;
              T_NONE:  Data_in <= '0;
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          Data_in   <= ram_dout;
          state_q   <= S_DONE;
          MIO_ready <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: randomized bus traffic against a
// word-level memory/peripheral model, plus reset and back-to-back scenarios.
module tb_mio_responder;
  localparam int          RAM_AW   = 10;
  localparam logic [15:0] LED_INIT = 16'h5A3C;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              CPU_MIO = 1'b0;
  logic              mem_w = 1'b0;
  logic [31:0]       Addr_out = '0;
  logic [31:0]       Data_out = '0;
  logic [31:0]       Data_in;
  logic              MIO_ready;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout = '0;
  logic [15:0]       sw = '0;
  logic [15:0]       led;
  logic [1:0]        state;

  mio_responder #(.RAM_AW(RAM_AW), .LED_INIT(LED_INIT)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .sw(sw), .led(led), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Synchronous RAM attached to the responder
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  initial for (int i = 0; i < (1<<RAM_AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  // Strobe and completion monitor
  int en_cnt = 0, en_b2b = 0, rdy_cnt = 0;
  logic prev_en = 1'b0;
  logic [RAM_AW-1:0] last_addr = '0;
  logic last_we = 1'b0;
  logic [31:0] last_din = '0;
  always @(posedge clk) begin
    if (ram_en && prev_en) en_b2b++;
    prev_en = ram_en;
    if (MIO_ready) rdy_cnt++;
    if (ram_en) begin
      en_cnt++;
      last_addr = ram_addr;
      last_we   = ram_we;
      last_din  = ram_din;
    end
  end

  // Reference model
  logic [31:0] exp_mem [int];
  logic [15:0] exp_led = LED_INIT;
  logic [31:0] exp_din = '0;
  logic [31:0] cnt_base = '0;
  int          cnt_edge = 0;

  function automatic logic [31:0] mem_get(input int word);
    return exp_mem.exists(word) ? exp_mem[word] : 32'h0;
  endfunction

  // Counter value just before the clock edge with index acc.
  function automatic logic [31:0] exp_cnt(input int acc);
    return cnt_base + 32'(acc - cnt_edge - 1);
  endfunction

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output int acc);
    int n;
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = w; Addr_out = a; Data_out = d;
    @(posedge clk); #1;
    acc = cyc + 1;
    n = 0;
    while (MIO_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    lat = n + 1;
    rd = Data_in;
    CPU_MIO = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int acc;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (MIO_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", MIO_ready); end
    checks++; if (Data_in !== 32'h0) begin failures++; $display("FAIL rst_data_in got=%h exp=0", Data_in); end
    checks++; if ({ram_en, ram_we} !== 2'b00) begin failures++; $display("FAIL rst_ram_strobe got=%b exp=00", {ram_en, ram_we}); end
    checks++; if (led !== LED_INIT) begin failures++; $display("FAIL rst_led got=%h exp=%h", led, LED_INIT); end
    // First request on the first edge after release: a counter read
    @(negedge clk);
    reset = 1'b1; CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'hF000_0004;
    cnt_base = '0; cnt_edge = cyc;
    @(posedge clk); #1;
    acc = cyc + 1;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL first_accept state got=%0d exp=1", state); end
    @(posedge clk); #1;
    checks++; if (MIO_ready !== 1'b1) begin failures++; $display("FAIL first_ready got=%b exp=1", MIO_ready); end
    exp_din = exp_cnt(acc);
    checks++; if (Data_in !== exp_din) begin failures++; $display("FAIL first_cnt got=%h exp=%h", Data_in, exp_din); end
    CPU_MIO = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ram();
    logic [31:0] rd, d, a, e;
    int lat, acc, e0, word;
    logic w;
    e0 = en_cnt;
    bus(1'b1, 32'h0000_0010, 32'hDEADBEEF, rd, lat, acc);
    exp_mem[4] = 32'hDEADBEEF;
    checks++; if (lat !== 2) begin failures++; $display("FAIL ram_wr_latency got=%0d exp=2", lat); end
    checks++; if (en_cnt - e0 !== 1) begin failures++; $display("FAIL ram_wr_en_count got=%0d exp=1", en_cnt - e0); end
    checks++; if ({last_we, last_addr, last_din} !== {1'b1, 10'd4, 32'hDEADBEEF}) begin
      failures++; $display("FAIL ram_wr_strobe got we=%b addr=%0d din=%h exp we=1 addr=4 din=deadbeef", last_we, last_addr, last_din); end
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL ram_wr_data_in_held got=%h exp=%h", rd, exp_din); end
    bus(1'b0, 32'h0000_0012, 32'h0, rd, lat, acc);
    exp_din = 32'hDEADBEEF;
    checks++; if (lat !== 3) begin failures++; $display("FAIL ram_rd_latency got=%0d exp=3", lat); end
    checks++; if ({last_we, last_addr} !== {1'b0, 10'd4}) begin failures++; $display("FAIL ram_rd_addr got we=%b addr=%0d exp we=0 addr=4", last_we, last_addr); end
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL ram_rd_data got=%h exp=%h", rd, exp_din); end
    checks++; if ({MIO_ready, state} !== 3'b000) begin failures++; $display("FAIL ready_one_cycle got ready=%b state=%0d exp 0/0", MIO_ready, state); end
    for (int i = 0; i < 26; i++) begin
      w    = 1'($urandom_range(0, 1));
      word = (i == 0) ? 1023 : int'($urandom_range(0, 1023));
      if (i == 1) begin w = 1'b0; word = 1023; end
      a = 32'(word * 4) | 32'($urandom_range(0, 3));
      d = $urandom;
      e0 = en_cnt;
      bus(w, a, d, rd, lat, acc);
      checks++; if (lat !== (w ? 2 : 3)) begin failures++; $display("FAIL ram_rand_latency got=%0d exp=%0d", lat, w ? 2 : 3); end
      checks++; if (en_cnt - e0 !== 1 || last_addr !== 10'(word)) begin
        failures++; $display("FAIL ram_rand_strobe got en=%0d addr=%0d exp en=1 addr=%0d", en_cnt - e0, last_addr, word); end
      if (w) begin
        exp_mem[word] = d;
        checks++; if (rd !== exp_din) begin failures++; $display("FAIL ram_rand_wr_held got=%h exp=%h", rd, exp_din); end
      end else begin
        e = mem_get(word);
        exp_din = e;
        checks++; if (rd !== e) begin failures++; $display("FAIL ram_rand_rd addr=%h got=%h exp=%h", a, rd, e); end
      end
    end
  endtask

  task automatic test_led();
    logic [31:0] rd, d;
    int lat, acc;
    bus(1'b1, 32'hE000_0000, 32'h1234_A5A5, rd, lat, acc);
    exp_led = 16'hA5A5;
    checks++; if (led !== exp_led) begin failures++; $display("FAIL led_wr got=%h exp=%h", led, exp_led); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL led_wr_latency got=%0d exp=2", lat); end
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL led_wr_data_in_held got=%h exp=%h", rd, exp_din); end
    bus(1'b0, 32'hE000_0000, 32'h0, rd, lat, acc);
    exp_din = {16'h0, exp_led};
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL led_rd got=%h exp=%h", rd, exp_din); end
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      bus(1'b1, 32'hE000_0000 | 32'($urandom_range(0, 3)), d, rd, lat, acc);
      exp_led = d[15:0];
      checks++; if (led !== exp_led) begin failures++; $display("FAIL led_rand_wr got=%h exp=%h", led, exp_led); end
      bus(1'b0, 32'hE000_0000 | 32'($urandom_range(0, 3)), 32'h0, rd, lat, acc);
      exp_din = {16'h0, exp_led};
      checks++; if (rd !== exp_din || lat !== 2) begin failures++; $display("FAIL led_rand_rd got=%h lat=%0d exp=%h lat=2", rd, lat, exp_din); end
    end
  endtask

  task automatic test_cnt();
    logic [31:0] rd, v;
    int lat, acc;
    bus(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat, acc);
    cnt_base = 32'hFFFF_FFFE; cnt_edge = acc;
    repeat (2) @(posedge clk);
    bus(1'b0, 32'hF000_0004, 32'h0, rd, lat, acc);
    exp_din = exp_cnt(acc);
    checks++; if (rd !== exp_din || lat !== 2) begin failures++; $display("FAIL cnt_wrap got=%h lat=%0d exp=%h lat=2", rd, lat, exp_din); end
    checks++; if (rd > 32'd16) begin failures++; $display("FAIL cnt_wrapped_small got=%h exp below 0x10", rd); end
    for (int i = 0; i < 5; i++) begin
      v = $urandom;
      bus(1'b1, 32'hF000_0004 | 32'($urandom_range(0, 3)), v, rd, lat, acc);
      cnt_base = v; cnt_edge = acc;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      bus(1'b0, 32'hF000_0004, 32'h0, rd, lat, acc);
      exp_din = exp_cnt(acc);
      checks++; if (rd !== exp_din) begin failures++; $display("FAIL cnt_rand got=%h exp=%h", rd, exp_din); end
    end
  endtask

  task automatic test_sw_unmapped();
    logic [31:0] rd;
    int lat, acc, e0;
    sw = 16'h00C3;
    repeat (3) @(posedge clk);
    bus(1'b0, 32'hF000_0000, 32'h0, rd, lat, acc);
    exp_din = 32'h0000_00C3;
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL sw_rd got=%h exp=%h", rd, exp_din); end
    for (int i = 0; i < 3; i++) begin
      sw = 16'($urandom);
      repeat (3) @(posedge clk);
      bus(1'b0, 32'hF000_0000, 32'h0, rd, lat, acc);
      exp_din = {16'h0, sw};
      checks++; if (rd !== exp_din) begin failures++; $display("FAIL sw_rand got=%h exp=%h", rd, exp_din); end
    end
    bus(1'b0, 32'h8000_0000, 32'h0, rd, lat, acc);
    exp_din = 32'h0;
    checks++; if (rd !== 32'h0 || lat !== 2) begin failures++; $display("FAIL unmapped_rd got=%h lat=%0d exp=0 lat=2", rd, lat); end
    bus(1'b0, 32'h0000_0010, 32'h0, rd, lat, acc);
    exp_din = mem_get(4);
    bus(1'b0, 32'h0000_1000, 32'h0, rd, lat, acc);
    exp_din = 32'h0;
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL above_ram_rd got=%h exp=0", rd); end
    e0 = en_cnt;
    bus(1'b1, 32'h8000_0000, 32'h0000_FFFF, rd, lat, acc);
    bus(1'b1, 32'hF000_0000, 32'h0000_1111, rd, lat, acc);
    checks++; if (lat !== 2 || rd !== exp_din) begin failures++; $display("FAIL nop_wr_complete lat=%0d data_in=%h exp lat=2 data_in=%h", lat, rd, exp_din); end
    checks++; if (en_cnt !== e0 || led !== exp_led) begin
      failures++; $display("FAIL nop_wr_side_effect en=%0d led=%h exp en=0 led=%h", en_cnt - e0, led, exp_led); end
    bus(1'b0, 32'hF000_0004, 32'h0, rd, lat, acc);
    exp_din = exp_cnt(acc);
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL nop_wr_cnt got=%h exp=%h", rd, exp_din); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat, acc, n, r0;
    bus(1'b1, 32'h0000_0020, 32'h0BAD_F00D, rd, lat, acc);
    exp_mem[8] = 32'h0BAD_F00D;
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h0000_0010;
    n = 0;
    while (state !== 2'd2 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL mid_reach_wait got=%0d exp=2", state); end
    #2 reset = 1'b0;
    #1;
    r0 = rdy_cnt;
    checks++; if ({MIO_ready, state} !== 3'b000 || Data_in !== 32'h0) begin
      failures++; $display("FAIL mid_rst_clear ready=%b state=%0d data_in=%h exp 0/0/0", MIO_ready, state, Data_in); end
    CPU_MIO = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_led = LED_INIT;
    checks++; if (rdy_cnt !== r0) begin failures++; $display("FAIL mid_rst_no_ready got=%0d exp=0", rdy_cnt - r0); end
    checks++; if (led !== exp_led) begin failures++; $display("FAIL mid_rst_led got=%h exp=%h", led, exp_led); end
    @(negedge clk);
    reset = 1'b1; cnt_base = '0; cnt_edge = cyc; exp_din = '0;
    // Reset during the ACCESS cycle of a RAM write must drop the write
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_out = 32'h0000_0020; Data_out = 32'h5555_AAAA;
    @(posedge clk); #1;
    checks++; if ({state, ram_en} !== 3'b011) begin failures++; $display("FAIL mid_wr_access state=%0d en=%b exp 1/1", state, ram_en); end
    reset = 1'b0;
    #1 CPU_MIO = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; cnt_base = '0; cnt_edge = cyc;
    bus(1'b0, 32'h0000_0020, 32'h0, rd, lat, acc);
    exp_din = mem_get(8);
    checks++; if (rd !== exp_din || lat !== 3) begin failures++; $display("FAIL mid_wr_dropped got=%h lat=%0d exp=%h lat=3", rd, lat, exp_din); end
    bus(1'b0, 32'hF000_0004, 32'h0, rd, lat, acc);
    exp_din = exp_cnt(acc);
    checks++; if (rd !== exp_din) begin failures++; $display("FAIL mid_cnt_after got=%h exp=%h", rd, exp_din); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d1, d2, v1, v2;
    int lat, acc, pulses, dbl, e0, b0;
    logic prev_rdy, idle_seen;
    v1 = $urandom; v2 = $urandom;
    bus(1'b1, 32'h0000_0014, v1, rd, lat, acc); exp_mem[5] = v1;
    bus(1'b1, 32'h0000_0018, v2, rd, lat, acc); exp_mem[6] = v2;
    e0 = en_cnt; b0 = en_b2b;
    pulses = 0; dbl = 0; prev_rdy = 1'b0; idle_seen = 1'b0; d1 = '0; d2 = '0;
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_out = 32'h0000_0014;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (MIO_ready && prev_rdy) dbl++;
      prev_rdy = MIO_ready;
      if (pulses == 1 && !MIO_ready && state == 2'd0) idle_seen = 1'b1;
      if (MIO_ready) begin
        pulses++;
        if (pulses == 1) begin d1 = Data_in; Addr_out = 32'h0000_0018; end
        else if (pulses == 2) begin d2 = Data_in; CPU_MIO = 1'b0; end
      end
    end
    exp_din = v2;
    checks++; if (pulses !== 2 || dbl !== 0) begin failures++; $display("FAIL b2b_pulses got=%0d wide=%0d exp=2 wide=0", pulses, dbl); end
    checks++; if (idle_seen !== 1'b1) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=1", idle_seen); end
    checks++; if (d1 !== v1 || d2 !== v2) begin failures++; $display("FAIL b2b_data got=%h,%h exp=%h,%h", d1, d2, v1, v2); end
    checks++; if (en_cnt - e0 !== 2 || en_b2b !== b0) begin
      failures++; $display("FAIL b2b_ram_en got=%0d consecutive=%0d exp=2 consecutive=0", en_cnt - e0, en_b2b - b0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_cnt();
    test_sw_unmapped();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter RAM_AW, default 10: RAM word-address width; RAM window is 4*2^RAM_AW bytes at 0x0000_0000.
REQ-002 Parameter LED_INIT, default 16'h0000: reset value of the LED register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 CPU_MIO  input  1  bus request from the CPU, held high until MIO_ready is seen.
REQ-006 mem_w  input  1  1 = write request, 0 = read request; sampled with CPU_MIO.
REQ-007 Addr_out  input  32  byte address from the CPU.
REQ-008 Data_out  input  32  write data from the CPU.
REQ-009 Data_in  output  32  read data to the CPU; registered.
REQ-010 MIO_ready  output  1  one-cycle completion pulse to the CPU.
REQ-011 ram_en, ram_we  output  1 each  synchronous RAM enable and write strobe.
REQ-012 ram_addr  output  RAM_AW  RAM word address.
REQ-013 ram_din  output  32  RAM write data.
REQ-014 ram_dout  input  32  RAM read data, valid one cycle after ram_en.
REQ-015 sw  input  16  asynchronous switch inputs.
REQ-016 led  output  16  LED register.
REQ-017 state  output  2  FSM state: IDLE=0, ACCESS=1, WAIT=2, DONE=3.

Function
REQ-018 Address decode is taken from the latched address:
- RAM: Addr_out[31:12+RAM_AW-10] == 0.
- LED: 0xE000_0000.
- SW: 0xF000_0000, read-only.
- CNT: 0xF000_0004.
- Anything else is unmapped.
REQ-019 Addr_out[1:0] is ignored and all accesses are full 32-bit words; ram_addr = latched Addr_out[RAM_AW+1:2].
REQ-020 In IDLE with CPU_MIO=1, the block latches Addr_out, Data_out and mem_w, then moves to ACCESS. With CPU_MIO=0 it stays in IDLE.
REQ-021 ACCESS, RAM target: ram_en=1 for exactly this cycle, and ram_we=latched mem_w. A RAM read moves to WAIT; a RAM write moves to DONE.
REQ-022 ACCESS, non-RAM target:
- LED write: led <= Data_out[15:0].
- CNT write: counter loads Data_out.
- Reads capture the target value into Data_in.
- Always moves to DONE.
REQ-023 WAIT: Data_in <= ram_dout, then moves to DONE.
REQ-024 DONE: MIO_ready=1 for exactly one cycle, then unconditionally moves to IDLE. A request is accepted no earlier than the cycle after DONE.
REQ-025 Read latency, request sampled to MIO_ready high: RAM read 3 cycles; RAM write and peripheral access 2 cycles.
REQ-026 Data_in holds its value from capture until the next read capture; writes do not change Data_in.
REQ-027 SW reads return {16'b0, sw_sync}. sw_sync is sw passed through a 2-flop synchronizer.
REQ-028 CNT is a 32-bit free-running counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0. A CNT write loads the written value that cycle, and the load takes precedence over the increment. A CNT read returns the pre-edge value in ACCESS.
REQ-029 Unmapped accesses and SW writes have no side effect; unmapped/SW-write completions still pulse MIO_ready, and unmapped reads return 32'h0.
REQ-030 ram_din = latched Data_out. ram_en and ram_we are 0 in every state except ACCESS-to-RAM.
REQ-031 CPU_MIO dropping mid-transaction does not abort it; the transaction completes normally.

Reset
REQ-032 When reset=0, asynchronously:
- state=IDLE, MIO_ready=0, Data_in=0, ram_en=0, ram_we=0.
- led=LED_INIT, counter=0, synchronizer flops=0, latched address/data/mem_w=0.
REQ-033 Reset asserted mid-transaction discards the transaction: no RAM or peripheral write occurs after the reset edge, and no MIO_ready pulse is produced.
REQ-034 After reset deasserts, the first request is accepted on the first rising edge with CPU_MIO=1.

Verification
REQ-035 RAM write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0012 -> ram_addr=4. Write completes with MIO_ready 2 cycles after request; read completes after 3 cycles with Data_in=0xDEADBEEF.
REQ-036 Write 0x1234_A5A5 to 0xE000_0000 -> led=16'hA5A5 after ACCESS. Reading it back returns Data_in=0x0000_A5A5.
REQ-037 Write 0xFFFF_FFFE to 0xF000_0004, idle 2 cycles, then read 0xF000_0004 -> Data_in shows the counter has wrapped past 0, i.e. load + elapsed cycles mod 2^32.
REQ-038 sw=16'h00C3 held stable, read 0xF000_0000 -> Data_in=0x0000_00C3. Read 0x8000_0000 -> Data_in=0. Write 0x8000_0000 -> MIO_ready pulses, no led/RAM/counter change.
REQ-039 Assert reset=0 during WAIT of a RAM read -> MIO_ready stays 0, state=0, Data_in=0. A request issued after release completes normally.
REQ-040 Hold CPU_MIO=1 continuously across two back-to-back reads -> exactly one MIO_ready per transaction, separated by at least one IDLE cycle, and ram_en never high two consecutive cycles.
